decode_regfile_stage: RTL and testbench

//  Y86-64 decode/write-back stage for the SEQ/PIPE cores: icode-driven srcA/srcB/dstE/dstM

---
 rtl/decode_regfile_stage_if.sv | 36 +++
 rtl/decode_regfile_stage.sv | 105 ++++++++++
 tb/tb_decode_regfile_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/decode_regfile_stage_if.sv
// decode_regfile_stage_if: fetch-in, D->E-out and write-back signal bundle for decode_regfile_stage
//   master: environment side (drives fetch inputs, out_ready, write-back; observes slot outputs)
//   slave : stage side (drives in_ready and the registered D->E slot)
interface decode_regfile_stage_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_icode;
    logic [3:0]        in_rA;
    logic [3:0]        in_rB;
    logic              bubble;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_icode;
    logic [DATA_W-1:0] out_valA;
    logic [DATA_W-1:0] out_valB;
    logic [3:0]        out_dstE;
    logic [3:0]        out_dstM;
    logic              out_err;
    logic              wb_en;
    logic [3:0]        wb_dstE;
    logic [DATA_W-1:0] wb_valE;
    logic [3:0]        wb_dstM;
    logic [DATA_W-1:0] wb_valM;
    modport master (
        output in_valid, in_icode, in_rA, in_rB, bubble, out_ready,
               wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM,
        input  in_ready, out_valid, out_icode, out_valA, out_valB, out_dstE, out_dstM, out_err
    );
    modport slave (
        input  in_valid, in_icode, in_rA, in_rB, bubble, out_ready,
               wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM,
        output in_ready, out_valid, out_icode, out_valA, out_valB, out_dstE, out_dstM, out_err
    );
endinterface

// File: rtl/decode_regfile_stage.sv
// decode_regfile_stage: Y86-64 decode/write-back stage with DEPTH-entry two-write-port register file
//   clk, rst_n (async active-low); bus (slave): fetch handshake in_*, bubble flush,
//   registered D->E slot out_* with out_valid/out_ready, write-back wb_en/wb_dstE/wb_valE/wb_dstM/wb_valM.
//   Optional WB_BYPASS_EN: slot captures same-cycle write-back data (M over E) instead of old contents.
module decode_regfile_stage #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 15,
    parameter int SP_IDX = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    decode_regfile_stage_if.slave bus
);
    localparam logic [3:0] SP    = 4'(SP_IDX);
    localparam logic [3:0] NONE  = 4'hF;
    localparam logic [4:0] DEPTH5 = 5'(DEPTH);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              valid_q, valid_d, err_q, err_d;
    logic [3:0]        icode_q, icode_d, dst_e_q, dst_e_d, dst_m_q, dst_m_d;
    logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
    logic [3:0]        ic, src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              take;

    function automatic logic in_rf(input logic [3:0] idx);
        return {1'b0, idx} < DEPTH5;
    endfunction

    function automatic logic [DATA_W-1:0] rd(input logic [3:0] idx);
        logic [DATA_W-1:0] v;
        v = in_rf(idx) ? regs_q[idx] : '0;
`ifdef WB_BYPASS_EN
        // M port wins over E port so a same-cycle popq %rsp forwards the popped value
        v = (bus.wb_en && in_rf(idx) && bus.wb_dstE == idx) ? bus.wb_valE : v;
        v = (bus.wb_en && in_rf(idx) && bus.wb_dstM == idx) ? bus.wb_valM : v;
`endif
        return v;
    endfunction

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_icode = icode_q;
    assign bus.out_valA  = val_a_q;
    assign bus.out_valB  = val_b_q;
    assign bus.out_dstE  = dst_e_q;
    assign bus.out_dstM  = dst_m_q;
    assign bus.out_err   = err_q;

    // Illegal icodes (>11) match none of the selections below, so all fields fall to NONE
    always_comb begin
        ic    = bus.in_icode;
        src_a = (ic == 4'd2 || ic == 4'd4 || ic == 4'd6 || ic == 4'd10) ? bus.in_rA :
                (ic == 4'd9 || ic == 4'd11) ? SP : NONE;
        src_b = (ic == 4'd4 || ic == 4'd5 || ic == 4'd6) ? bus.in_rB :
                (ic >= 4'd8 && ic <= 4'd11) ? SP : NONE;
        dst_e = (ic == 4'd2 || ic == 4'd3 || ic == 4'd6) ? bus.in_rB :
                (ic >= 4'd8 && ic <= 4'd11) ? SP : NONE;
        dst_m = (ic == 4'd5 || ic == 4'd11) ? bus.in_rA : NONE;
        rd_a  = rd(src_a);
        rd_b  = rd(src_b);
    end

    // E written first, then M, so equal destinations leave valM in the register
    always_comb begin
        regs_d = regs_q;
        if (bus.wb_en && in_rf(bus.wb_dstE)) regs_d[bus.wb_dstE] = bus.wb_valE;
        if (bus.wb_en && in_rf(bus.wb_dstM)) regs_d[bus.wb_dstM] = bus.wb_valM;
    end

    // When the slot opens, a bubble or an absent input loads a nop slot
    always_comb begin
        take    = bus.in_valid && !bus.bubble;
        valid_d = bus.in_ready ? take : valid_q;
        icode_d = bus.in_ready ? (take ? ic : 4'h1) : icode_q;
        val_a_d = bus.in_ready ? (take ? rd_a : '0) : val_a_q;
        val_b_d = bus.in_ready ? (take ? rd_b : '0) : val_b_q;
        dst_e_d = bus.in_ready ? (take ? dst_e : NONE) : dst_e_q;
        dst_m_d = bus.in_ready ? (take ? dst_m : NONE) : dst_m_q;
        err_d   = bus.in_ready ? (take && ic > 4'd11) : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q  <= '{default: '0};
            valid_q <= 1'b0;
            icode_q <= 4'h1;
            val_a_q <= '0;
            val_b_q <= '0;
            dst_e_q <= NONE;
            dst_m_q <= NONE;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
            icode_q <= icode_d;
            val_a_q <= val_a_d;
            val_b_q <= val_b_d;
            dst_e_q <= dst_e_d;
            dst_m_q <= dst_m_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_decode_regfile_stage.sv
// tb_decode_regfile_stage: directed self-checking bench for decode_regfile_stage
module tb_decode_regfile_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    decode_regfile_stage_if #(.DATA_W(64)) bus ();
    decode_regfile_stage #(.DATA_W(64), .DEPTH(15), .SP_IDX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic wb(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        bus.wb_en = 1'b1; bus.wb_dstE = de; bus.wb_valE = ve; bus.wb_dstM = dm; bus.wb_valM = vm;
        @(negedge clk);
        bus.wb_en = 1'b0;
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        bus.in_valid = 1'b1; bus.in_icode = ic; bus.in_rA = ra; bus.in_rB = rb;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_icode = 0; bus.in_rA = 0; bus.in_rB = 0; bus.bubble = 0; bus.out_ready = 1;
        bus.wb_en = 0; bus.wb_dstE = 4'hF; bus.wb_valE = 0; bus.wb_dstM = 4'hF; bus.wb_valM = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", bus.out_valid); end
        vectors++; if (bus.out_icode !== 4'h1) begin errors++; $display("FAIL rst_icode got %h want 1", bus.out_icode); end
        vectors++; if (bus.out_dstE !== 4'hF || bus.out_dstM !== 4'hF) begin errors++; $display("FAIL rst_dst got %h/%h want f/f", bus.out_dstE, bus.out_dstM); end
        vectors++; if (bus.out_err !== 1'b0 || bus.out_valA !== 64'd0) begin errors++; $display("FAIL rst_err_valA got %0b/%h want 0/0", bus.out_err, bus.out_valA); end
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); end
        send(4'd2, 4'd2, 4'd6);
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_valA !== 64'd0 || bus.out_dstE !== 4'd6) begin errors++; $display("FAIL rst_read_r2 got v=%0b valA=%h dstE=%h want 1/0/6", bus.out_valid, bus.out_valA, bus.out_dstE); end
    endtask

    task automatic test_opq();
        wb(4'd2, 64'd5, 4'd3, 64'd7);
        send(4'd6, 4'd2, 4'd3);
        vectors++; if (bus.out_valA !== 64'd5) begin errors++; $display("FAIL opq_valA got %h want 5", bus.out_valA); end
        vectors++; if (bus.out_valB !== 64'd7) begin errors++; $display("FAIL opq_valB got %h want 7", bus.out_valB); end
        vectors++; if (bus.out_dstE !== 4'd3 || bus.out_dstM !== 4'hF || bus.out_icode !== 4'd6) begin errors++; $display("FAIL opq_fields got dstE=%h dstM=%h icode=%h want 3/f/6", bus.out_dstE, bus.out_dstM, bus.out_icode); end
    endtask

    task automatic test_popq();
        wb(4'd4, 64'h100, 4'hF, 64'd0);
        send(4'd11, 4'd2, 4'hF);
        vectors++; if (bus.out_valA !== 64'h100 || bus.out_valB !== 64'h100) begin errors++; $display("FAIL popq_vals got %h/%h want 100/100", bus.out_valA, bus.out_valB); end
        vectors++; if (bus.out_dstE !== 4'd4 || bus.out_dstM !== 4'd2) begin errors++; $display("FAIL popq_dsts got %h/%h want 4/2", bus.out_dstE, bus.out_dstM); end
        wb(4'd4, 64'h108, 4'd4, 64'h55);
        send(4'd10, 4'd4, 4'hF);
        vectors++; if (bus.out_valA !== 64'h55 || bus.out_valB !== 64'h55) begin errors++; $display("FAIL popq_wb_m_wins got %h/%h want 55/55", bus.out_valA, bus.out_valB); end
        vectors++; if (bus.out_dstE !== 4'd4 || bus.out_dstM !== 4'hF) begin errors++; $display("FAIL pushq_dsts got %h/%h want 4/f", bus.out_dstE, bus.out_dstM); end
    endtask

    task automatic test_stall();
        bus.in_valid = 1; bus.in_icode = 4'd2; bus.in_rA = 4'd3; bus.in_rB = 4'd5;
        @(negedge clk);
        vectors++; if (bus.out_icode !== 4'd2 || bus.out_valA !== 64'd7 || bus.out_dstE !== 4'd5) begin errors++; $display("FAIL stall_loadA got icode=%h valA=%h dstE=%h want 2/7/5", bus.out_icode, bus.out_valA, bus.out_dstE); end
        bus.in_icode = 4'd6; bus.in_rA = 4'd2; bus.in_rB = 4'd3; bus.out_ready = 0;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b want 0", bus.in_ready); end
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_icode !== 4'd2 || bus.out_valA !== 64'd7) begin errors++; $display("FAIL stall_hold got v=%0b icode=%h valA=%h want 1/2/7", bus.out_valid, bus.out_icode, bus.out_valA); end
        bus.bubble = 1;
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_icode !== 4'd2 || bus.out_dstE !== 4'd5) begin errors++; $display("FAIL stall_bubble_ignored got v=%0b icode=%h dstE=%h want 1/2/5", bus.out_valid, bus.out_icode, bus.out_dstE); end
        bus.bubble = 0; bus.out_ready = 1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 0;
        vectors++; if (bus.out_icode !== 4'd6 || bus.out_valA !== 64'd5 || bus.out_valB !== 64'd7) begin errors++; $display("FAIL release_loadB got icode=%h valA=%h valB=%h want 6/5/7", bus.out_icode, bus.out_valA, bus.out_valB); end
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_bubble();
        send(4'd6, 4'd2, 4'd3);
        bus.bubble = 1;
        send(4'd6, 4'd2, 4'd3);
        bus.bubble = 0;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_icode !== 4'h1) begin errors++; $display("FAIL bubble_slot got v=%0b icode=%h want 0/1", bus.out_valid, bus.out_icode); end
        vectors++; if (bus.out_dstE !== 4'hF || bus.out_dstM !== 4'hF || bus.out_valA !== 64'd0) begin errors++; $display("FAIL bubble_fields got dstE=%h dstM=%h valA=%h want f/f/0", bus.out_dstE, bus.out_dstM, bus.out_valA); end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_e, exp_m;
`ifdef WB_BYPASS_EN
        exp_e = 64'd9; exp_m = 64'h22;
`else
        exp_e = 64'd5; exp_m = 64'd7;
`endif
        bus.wb_en = 1; bus.wb_dstE = 4'd2; bus.wb_valE = 64'd9; bus.wb_dstM = 4'hF; bus.wb_valM = 64'd0;
        send(4'd2, 4'd2, 4'd6);
        bus.wb_en = 0;
        vectors++; if (bus.out_valA !== exp_e) begin errors++; $display("FAIL bypass_e got %h want %h", bus.out_valA, exp_e); end
        send(4'd2, 4'd2, 4'd6);
        vectors++; if (bus.out_valA !== 64'd9) begin errors++; $display("FAIL after_wb_r2 got %h want 9", bus.out_valA); end
        bus.wb_en = 1; bus.wb_dstE = 4'd3; bus.wb_valE = 64'h11; bus.wb_dstM = 4'd3; bus.wb_valM = 64'h22;
        send(4'd2, 4'd3, 4'd6);
        bus.wb_en = 0;
        vectors++; if (bus.out_valA !== exp_m) begin errors++; $display("FAIL bypass_m_over_e got %h want %h", bus.out_valA, exp_m); end
    endtask

    task automatic test_illegal();
        send(4'd13, 4'd2, 4'd3);
        vectors++; if (bus.out_err !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_icode !== 4'd13) begin errors++; $display("FAIL illegal_err got err=%0b v=%0b icode=%h want 1/1/d", bus.out_err, bus.out_valid, bus.out_icode); end
        vectors++; if (bus.out_dstE !== 4'hF || bus.out_dstM !== 4'hF) begin errors++; $display("FAIL illegal_dsts got %h/%h want f/f", bus.out_dstE, bus.out_dstM); end
        vectors++; if (bus.out_valA !== 64'd0 || bus.out_valB !== 64'd0) begin errors++; $display("FAIL illegal_vals got %h/%h want 0/0", bus.out_valA, bus.out_valB); end
        send(4'd6, 4'd2, 4'd3);
        vectors++; if (bus.out_err !== 1'b0 || bus.out_valA !== 64'd9 || bus.out_valB !== 64'h22) begin errors++; $display("FAIL illegal_no_write got err=%0b valA=%h valB=%h want 0/9/22", bus.out_err, bus.out_valA, bus.out_valB); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_icode !== 4'h1 || bus.out_dstE !== 4'hF) begin errors++; $display("FAIL async_rst got v=%0b icode=%h dstE=%h want 0/1/f", bus.out_valid, bus.out_icode, bus.out_dstE); end
        @(negedge clk);
        rst_n = 1; bus.out_ready = 1;
        send(4'd6, 4'd2, 4'd3);
        vectors++; if (bus.out_valA !== 64'd0 || bus.out_valB !== 64'd0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL async_rst_regs got valA=%h valB=%h v=%0b want 0/0/1", bus.out_valA, bus.out_valB, bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_opq();
        test_popq();
        test_stall();
        test_bubble();
        test_bypass();
        test_illegal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
